// File: rtl/mult_rom_pkg.sv
// Shared definitions for the ROM-sequenced 8x8 shift-and-add multiplier:
// state encoding, control-word layout and iteration count.
package mult_rom_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;

   // Control word = {next_state[1:0], ld, iter, done}
   localparam int CW_W        = 5;
   localparam int CW_NEXT_LSB = 3;
   localparam int CW_NEXT_W   = 2;
   localparam int CW_LD       = 2;
   localparam int CW_ITER     = 1;
   localparam int CW_DONE     = 0;

   localparam int ROM_AW      = 4;
   localparam int ITERATIONS  = 8;

   typedef struct packed {
      state_t next;
      logic   ld;
      logic   iter;
      logic   done;
   } ctrl_t;

endpackage

// File: rtl/mult_ctrl_rom.sv
// Microcode ROM: {state, start, last-iteration flag} -> {next state, ld, iter, done}.
module mult_ctrl_rom
   import mult_rom_pkg::*;
(
   input  state_t state,
   input  logic   s,
   input  logic   cnt_last,
   output ctrl_t  ctrl
);

   logic [ROM_AW-1:0] addr;
   logic [CW_W-1:0]   word;

   assign addr = {state, s, cnt_last};

   always_comb begin
      word = '0;
      case (addr)
         4'b0000: word = {IDLE, 3'b000};
         4'b0001: word = {IDLE, 3'b000};
         4'b0010: word = {LOAD, 3'b000};
         4'b0011: word = {LOAD, 3'b000};
         4'b0100: word = {ITER, 3'b100};
         4'b0101: word = {ITER, 3'b100};
         4'b0110: word = {ITER, 3'b100};
         4'b0111: word = {ITER, 3'b100};
         4'b1000: word = {ITER, 3'b010};
         4'b1001: word = {DONE, 3'b011};
         4'b1010: word = {ITER, 3'b010};
         4'b1011: word = {DONE, 3'b011};
         4'b1100: word = {IDLE, 3'b000};
         4'b1101: word = {IDLE, 3'b000};
         4'b1110: word = {IDLE, 3'b000};
         4'b1111: word = {IDLE, 3'b000};
         default: word = {IDLE, 3'b000};
      endcase
   end

   assign ctrl = ctrl_t'(word);

endmodule

// File: rtl/multiplier_8bits_rom.sv
// Sequential 8x8 unsigned shift-and-add multiplier sequenced by a microcode ROM.
// Start with S in IDLE; the 16-bit product appears on result when PRONTO pulses.
module multiplier_8bits_rom
   import mult_rom_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        S,
   input  logic [7:0]  w,
   input  logic [7:0]  y,
   output logic [15:0] result,
   output logic        PRONTO
);

   state_t      state;
   ctrl_t       ctrl;
   logic [15:0] a;
   logic [7:0]  b;
   logic [15:0] p;
   logic [15:0] p_next;
   logic [3:0]  cnt;
   logic        cnt_last;

   mult_ctrl_rom u_rom (
      .state    (state),
      .s        (S),
      .cnt_last (cnt_last),
      .ctrl     (ctrl)
   );

   assign p_next = b[0] ? p + a : p;

   // cnt_last is registered, so the ROM sees it one ITER cycle after the 8th
   // shift; that trailing cycle has b == 0 and leaves the product unchanged.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= IDLE;
         a        <= '0;
         b        <= '0;
         p        <= '0;
         cnt      <= '0;
         cnt_last <= 1'b0;
         result   <= '0;
         PRONTO   <= 1'b0;
      end else begin
         state <= ctrl.next;
         if (ctrl.ld) begin
            a        <= {8'h00, w};
            b        <= y;
            p        <= '0;
            cnt      <= '0;
            cnt_last <= 1'b0;
         end else if (ctrl.iter) begin
            p        <= p_next;
            a        <= a << 1;
            b        <= b >> 1;
            cnt      <= cnt + 4'd1;
            cnt_last <= (cnt == 4'(ITERATIONS - 1));
         end
         if (ctrl.done)
            result <= p_next;
         PRONTO <= ctrl.done;
      end
   end

endmodule

// File: tb/tb_multiplier_8bits_rom.sv
// Scoreboard bench for multiplier_8bits_rom: directed operand pairs with
// hand-computed products and the cycle each PRONTO pulse is due.
module tb_multiplier_8bits_rom;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        S;
   logic [7:0]  w;
   logic [7:0]  y;
   logic [15:0] result;
   logic        PRONTO;

   typedef struct {
      logic [15:0] prod;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [15:0] model_result = '0;
   logic        prev_pronto = 1'b0;

   multiplier_8bits_rom dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .S      (S),
      .w      (w),
      .y      (y),
      .result (result),
      .PRONTO (PRONTO)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every negedge against the scoreboard / held model value.
   always @(negedge CLK) begin
      if (!RESET) begin
         model_result = '0;
         check("reset_result", {16'd0, result}, 32'd0);
         check("reset_pronto", {31'd0, PRONTO}, 32'd0);
      end else if (PRONTO) begin
         check("pronto_width", {31'd0, prev_pronto}, 32'd0);
         check("pronto_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("product", {16'd0, result}, {16'd0, e.prod});
            check("latency_cycle", cyc, e.due);
            model_result = e.prod;
         end
      end else begin
         check("result_stable", {16'd0, result}, {16'd0, model_result});
      end
      prev_pronto = PRONTO;
   end

   // Called at posedge+1; the following edge samples S in IDLE.
   task automatic start_op(input logic [7:0] wa, input logic [7:0] ya,
                           input logic [15:0] prod, input int due);
      w = wa;
      y = ya;
      S = 1'b1;
      sb.push_back('{prod: prod, due: due});
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge CLK);
      if (sb.size() != 0) begin
         check("done_timeout", sb.size(), 0);
         sb.delete();
      end
      repeat (2) @(posedge CLK);
      #1;
   endtask

   task automatic single_op(input logic [7:0] wa, input logic [7:0] ya, input logic [15:0] prod);
      start_op(wa, ya, prod, cyc + 11);
      @(posedge CLK); #1;
      S = 1'b0;
      wait_idle();
   endtask

   initial begin
      int e0;
      RESET = 1'b0; S = 1'b0; w = '0; y = '0;
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b1;

      // Idle with S low: no pulse, result held at 0
      repeat (15) @(posedge CLK);
      #1;

      single_op(8'd17,  8'd23,  16'd391);
      single_op(8'd255, 8'd255, 16'd65025);
      single_op(8'd0,   8'd200, 16'd0);
      single_op(8'd1,   8'd173, 16'd173);

      // S held high: back-to-back operations 12 cycles apart, operands re-sampled
      e0 = cyc + 1;
      start_op(8'd12, 8'd10, 16'd120, e0 + 10);
      @(posedge CLK); @(posedge CLK); #1;
      w = 8'd9; y = 8'd9;
      sb.push_back('{prod: 16'd81, due: e0 + 22});
      repeat (11) @(posedge CLK);
      #1 S = 1'b0;
      wait_idle();

      // Operand change during ITER must not disturb the running product
      start_op(8'd200, 8'd3, 16'd600, cyc + 11);
      repeat (3) @(posedge CLK);
      #1 S = 1'b0; w = 8'd7; y = 8'd7;
      wait_idle();

      // Asynchronous reset mid-operation, then a fresh operation
      start_op(8'd50, 8'd50, 16'd2500, cyc + 11);
      @(posedge CLK); #1 S = 1'b0;
      repeat (4) @(posedge CLK);
      #1 RESET = 1'b0;
      sb.delete();
      #1;
      check("async_reset_result", {16'd0, result}, 32'd0);
      check("async_reset_pronto", {31'd0, PRONTO}, 32'd0);
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b1;
      @(posedge CLK); #1;
      single_op(8'd13, 8'd11, 16'd143);

      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
